// File: rtl/addsub_arbiter_if.sv
// Handshake and result bus between two requesting clients and the shared
// 4-bit add/subtract arbiter.
interface addsub_arbiter_if;
    logic       req0;
    logic       req1;
    logic       m0;
    logic       m1;
    logic [3:0] x0;
    logic [3:0] y0;
    logic [3:0] x1;
    logic [3:0] y1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [3:0] result;
    logic       cout;
    logic       ovf;
    logic       busy;

    // Client side: drives requests and operands, observes grants and results.
    modport master (
        output req0, req1, m0, m1, x0, y0, x1, y1,
        input  gnt0, gnt1, done0, done1, result, cout, ovf, busy
    );

    // Arbiter side.
    modport slave (
        input  req0, req1, m0, m1, x0, y0, x1, y1,
        output gnt0, gnt1, done0, done1, result, cout, ovf, busy
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 4-bit ripple add/subtract unit between two
// requesters. Each service takes IDLE -> EXEC -> RESP, i.e. three cycles.
module addsub_arbiter (
    input  logic              clk,
    input  logic              resetn,
    addsub_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       ptr;
    logic       win;
    logic       pick;
    logic       op_m;
    logic [3:0] op_x;
    logic [3:0] op_y;
    logic [3:0] y_eff;
    logic [3:0] sum;
    logic [4:0] carry;
    logic       gnt0_r;
    logic       gnt1_r;
    logic       done0_r;
    logic       done1_r;
    logic [3:0] result_r;
    logic       cout_r;
    logic       ovf_r;

    // Signed overflow: carry into the MSB differs from carry out of it.
    function automatic logic signed_ovf(input logic c_in_msb, input logic c_out_msb);
        return c_in_msb ^ c_out_msb;
    endfunction

    // Ripple add/subtract fed only from the op registers; subtract is X + ~Y + 1.
    always_comb begin
        y_eff    = op_m ? ~op_y : op_y;
        carry    = '0;
        sum      = '0;
        carry[0] = op_m;
        for (int i = 0; i < 4; i++) begin
            sum[i]     = op_x[i] ^ y_eff[i] ^ carry[i];
            carry[i+1] = (op_x[i] & y_eff[i]) | (carry[i] & (op_x[i] ^ y_eff[i]));
        end
    end

    // Winner selection: a lone request wins, a tie goes to the pointer.
    always_comb begin
        pick = (bus.req0 && bus.req1) ? ptr : bus.req1;
    end

    // Control FSM with registered grant, done and result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            win      <= 1'b0;
            op_m     <= 1'b0;
            op_x     <= 4'd0;
            op_y     <= 4'd0;
            gnt0_r   <= 1'b0;
            gnt1_r   <= 1'b0;
            done0_r  <= 1'b0;
            done1_r  <= 1'b0;
            result_r <= 4'd0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win    <= pick;
                        op_m   <= pick ? bus.m1 : bus.m0;
                        op_x   <= pick ? bus.x1 : bus.x0;
                        op_y   <= pick ? bus.y1 : bus.y0;
                        gnt0_r <= ~pick;
                        gnt1_r <= pick;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_r <= sum;
                    cout_r   <= carry[4];
                    ovf_r    <= signed_ovf(carry[3], carry[4]);
                    done0_r  <= ~win;
                    done1_r  <= win;
                    state    <= RESP;
                end
                RESP: begin
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                    done0_r <= 1'b0;
                    done1_r <= 1'b0;
                    ptr     <= ~win;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0   = gnt0_r;
    assign bus.gnt1   = gnt1_r;
    assign bus.done0  = done0_r;
    assign bus.done1  = done1_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
    assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios plus randomized
// transactions against an arithmetic reference model.
module tb_addsub_arbiter;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;
    bit   mptr;

    addsub_arbiter_if bus ();

    addsub_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it does not match.
    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference result from integer arithmetic on the operand values.
    function automatic void model(input bit m, input int x, input int y,
                                  output int r, output int c, output int o);
        int sx;
        int sy;
        int full;
        int sres;
        sx = (x > 7) ? x - 16 : x;
        sy = (y > 7) ? y - 16 : y;
        if (!m) begin
            full = x + y;
            sres = sx + sy;
        end else begin
            full = x + (15 - y) + 1;
            sres = sx - sy;
        end
        r = full % 16;
        c = (full >= 16) ? 1 : 0;
        o = (sres > 7 || sres < -8) ? 1 : 0;
    endfunction

    // Present one request pattern and check the whole three-cycle service.
    task automatic do_op(input bit r0, input bit r1,
                         input bit a_m0, input logic [3:0] a_x0, input logic [3:0] a_y0,
                         input bit a_m1, input logic [3:0] a_x1, input logic [3:0] a_y1,
                         input bit scramble, input string tag);
        int w;
        int er;
        int ec;
        int eo;
        bus.req0 = r0; bus.req1 = r1;
        bus.m0 = a_m0; bus.x0 = a_x0; bus.y0 = a_y0;
        bus.m1 = a_m1; bus.x1 = a_x1; bus.y1 = a_y1;
        if (!r0 && !r1) begin
            @(posedge clk); #1;
            check({tag, "_idle_busy"}, bus.busy, 0);
            check({tag, "_idle_gnt"}, {bus.gnt1, bus.gnt0}, 0);
            return;
        end
        w = (r0 && r1) ? int'(mptr) : (r1 ? 1 : 0);
        if (w == 1) model(a_m1, a_x1, a_y1, er, ec, eo);
        else        model(a_m0, a_x0, a_y0, er, ec, eo);
        @(posedge clk); #1;
        check({tag, "_gnt0"}, bus.gnt0, (w == 0) ? 1 : 0);
        check({tag, "_gnt1"}, bus.gnt1, (w == 1) ? 1 : 0);
        check({tag, "_busy_exec"}, bus.busy, 1);
        check({tag, "_done_early"}, {bus.done1, bus.done0}, 0);
        if (scramble) begin
            bus.x0 = ~a_x0; bus.x1 = ~a_x1;
            bus.y0 = 4'($urandom); bus.y1 = 4'($urandom);
            bus.m0 = ~a_m0; bus.m1 = ~a_m1;
            bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, "_done0"}, bus.done0, (w == 0) ? 1 : 0);
        check({tag, "_done1"}, bus.done1, (w == 1) ? 1 : 0);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_cout"}, bus.cout, ec);
        check({tag, "_ovf"}, bus.ovf, eo);
        check({tag, "_busy_resp"}, bus.busy, 1);
        check({tag, "_gnt_hold"}, {bus.gnt1, bus.gnt0}, (w == 1) ? 2 : 1);
        @(posedge clk); #1;
        check({tag, "_done_clr"}, {bus.done1, bus.done0}, 0);
        check({tag, "_gnt_clr"}, {bus.gnt1, bus.gnt0}, 0);
        check({tag, "_busy_idle"}, bus.busy, 0);
        check({tag, "_result_held"}, bus.result, er);
        mptr = (w == 0);
    endtask

    // Asynchronous reset pulse spanning one rising edge.
    task automatic pulse_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        mptr = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mptr  = 1'b0;
        resetn = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.m0 = 1'b0; bus.m1 = 1'b0;
        bus.x0 = 4'd0; bus.y0 = 4'd0; bus.x1 = 4'd0; bus.y1 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
        check("rst_done", {bus.done1, bus.done0}, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", {bus.cout, bus.ovf}, 0);
        check("rst_busy", bus.busy, 0);
        resetn = 1'b1;

        // Reset in the middle of an operation discards it.
        bus.req0 = 1'b1; bus.m0 = 1'b0; bus.x0 = 4'd7; bus.y0 = 4'd7;
        @(posedge clk); #1;
        check("midrst_gnt0_pre", bus.gnt0, 1);
        resetn = 1'b0;
        #1;
        check("midrst_gnt", {bus.gnt1, bus.gnt0}, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_result", bus.result, 0);
        check("midrst_flags", {bus.cout, bus.ovf}, 0);
        @(posedge clk); #1;
        check("midrst_done", {bus.done1, bus.done0}, 0);
        resetn = 1'b1;
        mptr = 1'b0;
        do_op(1, 1, 0, 4'd1, 4'd2, 0, 4'd3, 4'd4, 0, "postrst");

        // Directed single operations.
        do_op(1, 0, 0, 4'b0101, 4'b0011, 0, 4'd0, 4'd0, 0, "add0");
        do_op(0, 1, 0, 4'd0, 4'd0, 1, 4'b0011, 4'b0101, 0, "sub1");

        // Round-robin with both requests held across three services.
        pulse_reset();
        do_op(1, 1, 0, 4'd2, 4'd3, 1, 4'd9, 4'd4, 0, "rr_a");
        do_op(1, 1, 0, 4'd2, 4'd3, 1, 4'd9, 4'd4, 0, "rr_b");
        do_op(1, 1, 0, 4'd2, 4'd3, 1, 4'd9, 4'd4, 0, "rr_c");

        // Subtract boundaries.
        do_op(1, 0, 1, 4'b0111, 4'b0111, 0, 4'd0, 4'd0, 0, "sub_zero");
        do_op(0, 1, 0, 4'd0, 4'd0, 1, 4'b1000, 4'b0001, 0, "sub_ovf");

        // Inputs changed and request dropped while in flight.
        do_op(1, 0, 0, 4'b0001, 4'b0001, 0, 4'd0, 4'd0, 1, "stable");
        @(posedge clk); #1;
        check("stable_no_second", {bus.gnt1, bus.gnt0}, 0);
        check("stable_idle", bus.busy, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
